acm_queued: RTL and testbench
=============================

Name: acm_queued

Overview:
- Parametrised successor of the register-file automatic correction mechanism. Holds the SECDED checksum file for a REGS-entry, 32-bit register file.
- Checks RPORTS read ports every cycle and reports correctable (CE) and uncorrectable (UCE) errors per port.
- Buffers repair requests in a QDEPTH-entry queue and writes corrected values back through the shared register-file write port whenever writeback is idle.
- Sits beside the register file in the OP stage and owns the write port mux.

Parameters:
- REGS, 32, number of architectural registers (power of 2, >=4); AW = $clog2(REGS)
- RPORTS, 2, number of checked read ports (1..4)
- QDEPTH, 2, repair-queue depth (1..8)
- SCRUB_PERIOD, 16, idle cycles before a scrub read (only with ACM_SCRUB_EN)

Ports:
- s_clk_i  in  1  clock
- s_resetn_i  in  1  asynchronous active-low reset
- s_wb_we_i  in  1  WB stage writes a register
- s_wb_add_i  in  AW  WB destination address
- s_wb_val_i  in  32  WB result
- s_r_add_i  in  RPORTS*AW  read-port addresses (port p at [p*AW+:AW])
- s_r_val_i  in  RPORTS*32  raw values read from register file
- s_fwd_i  in  RPORTS  operand of port p is forwarded (not taken from file)
- s_ce_o  out  RPORTS  correctable error at port p
- s_uce_o  out  RPORTS  uncorrectable error at port p
- s_we_o  out  1  register-file write enable
- s_add_o  out  AW  register-file write address
- s_val_o  out  32  register-file write data
- s_qfull_o  out  1  repair queue full
- s_drop_o  out  1  pulse: repair request lost (queue full)
- s_fix_cnt_o  out  16  saturating count of repair writes issued
- s_scrub_req_o  out  1  scrub read request
- s_scrub_add_o  out  AW  scrub read address
- s_scrub_val_i  in  32  value for s_scrub_add_o, valid cycle after request
- s_scrub_uce_o  out  1  pulse: scrub found UCE

Behaviour:
- Reset (async, active-low): checksum file all 7'b0 (codeword of 0); queue empty; s_fix_cnt_o=0; all outputs 0; scrub FSM IDLE, pointer=1.
- Per port p: syndrome = encode(val_p) ^ chk[add_p]. CE/UCE are combinational and forced 0 when add_p==0.
- Repair request p = CE_p & ~s_fwd_i[p] & ~(s_wb_we_i & s_wb_add_i==add_p).
- At most one enqueue per cycle; highest port index wins; losing requests are dropped silently (re-detected on the next read).
- No enqueue if the address is already queued and valid.
- Enqueue when full: no write, s_drop_o=1 for one cycle.
- Entry = {valid, add, corrected 32-bit value}. A WB write whose address matches a valid entry clears that entry's valid bit the same cycle.
- Write port: WB has priority. s_we_o = s_wb_we_i | issue, where issue = head valid & ~s_wb_we_i. Address/value come from WB, else from the head entry.
- Checksum file updated on posedge with encode(s_val_o) at s_add_o when s_we_o.
- Head pops when issued or when invalid (an invalid head pops regardless of WB, with no write).
- Simultaneous enqueue and pop at full: allowed, no drop.
- Latency: CE seen in cycle N -> repair write earliest in cycle N+1.
- s_fix_cnt_o increments per issue and saturates at 16'hFFFF.

Optional Feature:
- Macro ACM_SCRUB_EN enables the background scrubber FSM with states IDLE -> WAIT -> READ -> CHECK -> WAIT.
- WAIT counts consecutive cycles with ~s_wb_we_i and queue empty; any WB write or non-empty queue clears the counter. Reaching SCRUB_PERIOD-1 moves to READ.
- READ: s_scrub_req_o=1, s_scrub_add_o=pointer for one cycle.
- CHECK: syndrome from s_scrub_val_i.
  - CE: enqueue at lowest priority; skipped if a port enqueues this cycle, and the pointer does not advance.
  - UCE: s_scrub_uce_o pulse.
  - Otherwise the pointer advances, wrapping REGS-1 -> 1 (x0 skipped).
- A WB write to the pointer address during READ/CHECK discards the result; the pointer is kept.
- Without the macro: the scrub outputs are tied 0 and s_scrub_val_i is ignored.

Test Plan:
- WB writes x5=0xDEADBEEF, then port 0 reads x5 with bit 3 flipped, fwd=0 -> s_ce_o[0]=1 same cycle; next cycle s_we_o=1, add=5, val=0xDEADBEEF; s_fix_cnt_o=1.
- Ports 0 and 1 both CE (x3, x7) in one cycle -> only x7 queued and written; x3 re-detected on re-read.
- QDEPTH=2 with s_wb_we_i held high, three distinct CEs -> s_qfull_o=1 after the second; third gives s_drop_o pulse; writes resume once WB is idle.
- x9 queued, then WB writes x9=0x1 before issue -> entry invalidated, no repair write, final x9=0x1.
- Two-bit flip read on x4 -> s_uce_o=1, no enqueue. Any error on address 0 -> ce/uce=0.
- ACM_SCRUB_EN, SCRUB_PERIOD=16, idle: s_scrub_req_o after 16 cycles at add 1. Single-bit-flipped value returned -> repair write to x1 two cycles later. Pointer wraps 31 -> 1.

Source files
------------

// File: rtl/acm_queued.sv
// Register-file SECDED checker with a queued repair write-back path.
// Optional background scrubber enabled by defining ACM_SCRUB_EN.
module acm_queued #(
  parameter int REGS         = 32,
  parameter int RPORTS       = 2,
  parameter int QDEPTH       = 2,
  parameter int SCRUB_PERIOD = 16,
  localparam int AW          = $clog2(REGS)
) (
  input  logic                 s_clk_i,
  input  logic                 s_resetn_i,
  input  logic                 s_wb_we_i,
  input  logic [AW-1:0]        s_wb_add_i,
  input  logic [31:0]          s_wb_val_i,
  input  logic [RPORTS*AW-1:0] s_r_add_i,
  input  logic [RPORTS*32-1:0] s_r_val_i,
  input  logic [RPORTS-1:0]    s_fwd_i,
  output logic [RPORTS-1:0]    s_ce_o,
  output logic [RPORTS-1:0]    s_uce_o,
  output logic                 s_we_o,
  output logic [AW-1:0]        s_add_o,
  output logic [31:0]          s_val_o,
  output logic                 s_qfull_o,
  output logic                 s_drop_o,
  output logic [15:0]          s_fix_cnt_o,
  output logic                 s_scrub_req_o,
  output logic [AW-1:0]        s_scrub_add_o,
  input  logic [31:0]          s_scrub_val_i,
  output logic                 s_scrub_uce_o
);

  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] add;
    logic [31:0]   val;
  } ent_t;

  // Data bit k sits at the k-th non-power-of-two
  // Hamming position (3..38); bit 6 is overall parity.
  function automatic logic [6:0] ecc_enc(
    input logic [31:0] d
  );
    logic [6:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) c = c ^ {1'b1, p[5:0]};
        k++;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] ecc_fix(
    input logic [31:0] d,
    input logic [6:0]  s
  );
    logic [31:0] r;
    int k;
    r = d;
    k = 0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (s[5:0] == p[5:0]) r[k] = ~r[k];
        k++;
      end
    end
    return r;
  endfunction

  logic [6:0]    chk_q [REGS];
  logic [6:0]    chk_d [REGS];
  ent_t          q_q [QDEPTH];
  ent_t          q_d [QDEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   fix_q, fix_d;

  logic [AW-1:0] r_add [RPORTS];
  logic [31:0]   r_val [RPORTS];
  logic [6:0]    r_syn [RPORTS];

  logic          p_want;
  logic [AW-1:0] p_add;
  logic [31:0]   p_val;

  logic          sc_ce;
  logic [AW-1:0] sc_add;
  logic [31:0]   sc_val;

  logic          want, dup, full;
  logic          acc, drop, pop, issue;
  logic [AW-1:0] e_add;
  logic [31:0]   e_val;
  logic [CW-1:0] wr_idx;

  always_comb begin
    s_ce_o  = '0;
    s_uce_o = '0;
    p_want  = 1'b0;
    p_add   = '0;
    p_val   = '0;
    for (int p = 0; p < RPORTS; p++) begin
      r_add[p] = s_r_add_i[p*AW +: AW];
      r_val[p] = s_r_val_i[p*32 +: 32];
      r_syn[p] = ecc_enc(r_val[p]) ^ chk_q[r_add[p]];
      if (r_add[p] != '0) begin
        s_ce_o[p]  = r_syn[p][6];
        s_uce_o[p] = ~r_syn[p][6] & (|r_syn[p][5:0]);
      end
      // Later ports overwrite: highest index wins.
      if (s_ce_o[p] && !s_fwd_i[p] &&
          !(s_wb_we_i && s_wb_add_i == r_add[p])) begin
        p_want = 1'b1;
        p_add  = r_add[p];
        p_val  = ecc_fix(r_val[p], r_syn[p]);
      end
    end
  end

  always_comb begin
    want  = p_want;
    e_add = p_add;
    e_val = p_val;
    if (!p_want && sc_ce) begin
      want  = 1'b1;
      e_add = sc_add;
      e_val = sc_val;
    end
    dup = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (CW'(i) < cnt_q && q_q[i].vld &&
          q_q[i].add == e_add) dup = 1'b1;
    end
    full   = (cnt_q == CW'(QDEPTH));
    issue  = (cnt_q != '0) && q_q[0].vld && !s_wb_we_i;
    pop    = (cnt_q != '0) && (issue || !q_q[0].vld);
    acc    = want && !dup && (!full || pop);
    drop   = want && !dup && full && !pop;
    wr_idx = cnt_q - CW'(pop);
    cnt_d  = cnt_q - CW'(pop) + CW'(acc);

    q_d = q_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (s_wb_we_i && q_q[i].add == s_wb_add_i)
        q_d[i].vld = 1'b0;
    end
    if (pop) begin
      for (int i = 0; i < QDEPTH - 1; i++)
        q_d[i] = q_d[i+1];
      q_d[QDEPTH-1] = '0;
    end
    for (int i = 0; i < QDEPTH; i++) begin
      if (acc && CW'(i) == wr_idx)
        q_d[i] = '{vld: 1'b1, add: e_add, val: e_val};
    end

    fix_d = fix_q;
    if (issue && fix_q != 16'hFFFF)
      fix_d = fix_q + 16'd1;
  end

  always_comb begin
    s_we_o  = s_wb_we_i | issue;
    s_add_o = '0;
    s_val_o = '0;
    if (s_wb_we_i) begin
      s_add_o = s_wb_add_i;
      s_val_o = s_wb_val_i;
    end else if (issue) begin
      s_add_o = q_q[0].add;
      s_val_o = q_q[0].val;
    end
    chk_d = chk_q;
    if (s_we_o) chk_d[s_add_o] = ecc_enc(s_val_o);
  end

  assign s_qfull_o   = full;
  assign s_drop_o    = drop;
  assign s_fix_cnt_o = fix_q;

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      for (int i = 0; i < REGS; i++) chk_q[i] <= '0;
      for (int i = 0; i < QDEPTH; i++) q_q[i] <= '0;
      cnt_q <= '0;
      fix_q <= '0;
    end else begin
      chk_q <= chk_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
      fix_q <= fix_d;
    end
  end

`ifdef ACM_SCRUB_EN
  localparam int WCW = $clog2(SCRUB_PERIOD + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_READ, S_CHECK
  } sc_st_t;

  sc_st_t         st_q, st_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0]  ptr_q, ptr_d, ptr_nx;
  logic           disc_q, disc_d;
  logic [6:0]     sc_syn;
  logic           wb_hit, chk_ok;

  assign sc_syn = ecc_enc(s_scrub_val_i) ^ chk_q[ptr_q];
  assign wb_hit = s_wb_we_i && s_wb_add_i == ptr_q;
  assign chk_ok = (st_q == S_CHECK) && !disc_q && !wb_hit;
  assign sc_ce  = chk_ok && sc_syn[6];
  assign sc_add = ptr_q;
  assign sc_val = ecc_fix(s_scrub_val_i, sc_syn);
  assign ptr_nx = (ptr_q == AW'(REGS - 1)) ?
                  AW'(1) : ptr_q + AW'(1);

  always_comb begin
    st_d          = st_q;
    wcnt_d        = wcnt_q;
    ptr_d         = ptr_q;
    disc_d        = disc_q;
    s_scrub_req_o = 1'b0;
    s_scrub_add_o = '0;
    s_scrub_uce_o = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        st_d   = S_WAIT;
        wcnt_d = '0;
      end
      S_WAIT: begin
        if (s_wb_we_i || cnt_q != '0) begin
          wcnt_d = '0;
        end else if (wcnt_q == WCW'(SCRUB_PERIOD - 1)) begin
          st_d   = S_READ;
          wcnt_d = '0;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      S_READ: begin
        s_scrub_req_o = 1'b1;
        s_scrub_add_o = ptr_q;
        disc_d        = wb_hit;
        st_d          = S_CHECK;
      end
      S_CHECK: begin
        st_d   = S_WAIT;
        wcnt_d = '0;
        disc_d = 1'b0;
        // A CE that could not be queued is retried next round.
        if (chk_ok) begin
          if (sc_syn[6]) begin
            if (!p_want && !drop) ptr_d = ptr_nx;
          end else begin
            s_scrub_uce_o = |sc_syn[5:0];
            ptr_d         = ptr_nx;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      st_q   <= S_IDLE;
      wcnt_q <= '0;
      ptr_q  <= AW'(1);
      disc_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      wcnt_q <= wcnt_d;
      ptr_q  <= ptr_d;
      disc_q <= disc_d;
    end
  end
`else
  logic scrub_unused;

  assign scrub_unused  = ^s_scrub_val_i;
  assign sc_ce         = 1'b0;
  assign sc_add        = '0;
  assign sc_val        = '0;
  assign s_scrub_req_o = 1'b0;
  assign s_scrub_add_o = '0;
  assign s_scrub_uce_o = 1'b0;
`endif

endmodule

// File: tb/tb_acm_queued.sv
// Directed checks for acm_queued: detection, repair queue,
// WB priority/invalidation and (with ACM_SCRUB_EN) the scrubber.
module tb_acm_queued;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_add;
  logic [31:0] wb_val;
  logic [9:0]  r_add;
  logic [63:0] r_val;
  logic [1:0]  fwd;
  logic [1:0]  ce, uce;
  logic        we;
  logic [4:0]  add;
  logic [31:0] val;
  logic        qfull, drop;
  logic [15:0] fix;
  logic        sreq;
  logic [4:0]  sadd;
  logic [31:0] sval;
  logic        suce;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  acm_queued dut (
    .s_clk_i       (clk),
    .s_resetn_i    (rst_n),
    .s_wb_we_i     (wb_we),
    .s_wb_add_i    (wb_add),
    .s_wb_val_i    (wb_val),
    .s_r_add_i     (r_add),
    .s_r_val_i     (r_val),
    .s_fwd_i       (fwd),
    .s_ce_o        (ce),
    .s_uce_o       (uce),
    .s_we_o        (we),
    .s_add_o       (add),
    .s_val_o       (val),
    .s_qfull_o     (qfull),
    .s_drop_o      (drop),
    .s_fix_cnt_o   (fix),
    .s_scrub_req_o (sreq),
    .s_scrub_add_o (sadd),
    .s_scrub_val_i (sval),
    .s_scrub_uce_o (suce)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] a0,
                    input logic [31:0] v0,
                    input logic [4:0] a1,
                    input logic [31:0] v1);
    r_add = {a1, a0};
    r_val = {v1, v0};
  endtask

  task automatic wb(input logic w,
                    input logic [4:0] a,
                    input logic [31:0] v);
    wb_we  = w;
    wb_add = a;
    wb_val = v;
  endtask

  task automatic idle;
    wb(1'b0, 5'd0, 32'h0);
    rd(5'd0, 32'h0, 5'd0, 32'h0);
    fwd  = 2'b00;
    sval = 32'h0;
  endtask

  task automatic wr_chk(input string tag,
                        input logic [4:0] a,
                        input logic [31:0] v);
    check({tag, "_we"}, 32'(we), 32'd1);
    check({tag, "_add"}, 32'(add), 32'(a));
    check({tag, "_val"}, val, v);
  endtask

`ifdef ACM_SCRUB_EN
  task automatic wait_req(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      smp();
      if (sreq) begin
        ok = 1'b1;
        return;
      end
    end
  endtask
`endif

  initial begin
    idle();
    repeat (3) smp();
    check("rst_we", 32'(we), 32'd0);
    check("rst_qfull", 32'(qfull), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_fix", 32'(fix), 32'd0);
    check("rst_sreq", 32'(sreq), 32'd0);
    tick();
    rst_n = 1'b1;

    // single-bit CE on x5, repaired next cycle
    tick(); wb(1'b1, 5'd5, 32'hDEADBEEF);
    smp(); wr_chk("wb5", 5'd5, 32'hDEADBEEF);
    tick(); idle(); rd(5'd5, 32'hDEADBEE7, 5'd0, 32'h0);
    smp(); check("ce5", 32'(ce), 32'd1);
    check("uce5", 32'(uce), 32'd0);
    check("we5_same", 32'(we), 32'd0);
    tick(); idle();
    smp(); wr_chk("fix5", 5'd5, 32'hDEADBEEF);
    tick(); idle();
    smp(); check("cnt1", 32'(fix), 32'd1);
    check("we5_done", 32'(we), 32'd0);

    // two ports CE together: highest port wins
    tick(); rd(5'd3, 32'h10, 5'd7, 32'h100);
    smp(); check("ce37", 32'(ce), 32'd3);
    check("qfull0", 32'(qfull), 32'd0);
    tick(); idle();
    smp(); wr_chk("fix7", 5'd7, 32'h0);
    tick(); idle();
    smp(); check("x3_lost", 32'(we), 32'd0);
    check("cnt2", 32'(fix), 32'd2);
    tick(); rd(5'd3, 32'h10, 5'd0, 32'h0);
    smp(); check("ce3_again", 32'(ce), 32'd1);
    tick(); idle();
    smp(); wr_chk("fix3", 5'd3, 32'h0);

    // queue fills while WB is busy
    tick(); wb(1'b1, 5'd20, 32'h55);
    rd(5'd10, 32'h1, 5'd0, 32'h0);
    smp(); check("ce10", 32'(ce), 32'd1);
    check("qf_a", 32'(qfull), 32'd0);
    check("drop_a", 32'(drop), 32'd0);
    tick(); rd(5'd11, 32'h2, 5'd0, 32'h0);
    smp(); check("qf_b", 32'(qfull), 32'd0);
    check("drop_b", 32'(drop), 32'd0);
    tick(); rd(5'd12, 32'h4, 5'd0, 32'h0);
    smp(); check("qf_c", 32'(qfull), 32'd1);
    check("drop_c", 32'(drop), 32'd1);
    wr_chk("wb_prio", 5'd20, 32'h55);
    tick(); idle();
    smp(); check("drop_off", 32'(drop), 32'd0);
    wr_chk("fix10", 5'd10, 32'h0);
    tick(); idle();
    smp(); wr_chk("fix11", 5'd11, 32'h0);
    check("qf_d", 32'(qfull), 32'd0);
    tick(); idle();
    smp(); check("q_empty_we", 32'(we), 32'd0);
    check("cnt5", 32'(fix), 32'd5);

    // WB overwrite invalidates a queued repair
    tick(); wb(1'b1, 5'd20, 32'h55);
    rd(5'd9, 32'h8, 5'd0, 32'h0);
    smp(); check("ce9", 32'(ce), 32'd1);
    tick(); idle(); wb(1'b1, 5'd9, 32'h1);
    smp(); wr_chk("wb9", 5'd9, 32'h1);
    tick(); idle();
    smp(); check("inv_nowr", 32'(we), 32'd0);
    tick(); rd(5'd9, 32'h1, 5'd0, 32'h0);
    smp(); check("x9_ce", 32'(ce), 32'd0);
    check("x9_uce", 32'(uce), 32'd0);
    check("cnt5b", 32'(fix), 32'd5);

    // double-bit error, address zero, forwarded operand
    tick(); idle(); rd(5'd4, 32'h3, 5'd0, 32'h0);
    smp(); check("uce4", 32'(uce), 32'd1);
    check("uce4_ce", 32'(ce), 32'd0);
    tick(); idle();
    smp(); check("uce_nowr", 32'(we), 32'd0);
    tick(); rd(5'd0, 32'h1, 5'd0, 32'h6);
    smp(); check("x0_ce", 32'(ce), 32'd0);
    check("x0_uce", 32'(uce), 32'd0);
    tick(); idle(); fwd = 2'b01;
    rd(5'd6, 32'h1, 5'd0, 32'h0);
    smp(); check("fwd_ce", 32'(ce), 32'd1);
    tick(); idle();
    smp(); check("fwd_nowr", 32'(we), 32'd0);

`ifdef ACM_SCRUB_EN
    begin
      logic ok;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      idle();
      wait_req(ok);
      check("scrub_to1", 32'(ok), 32'd1);
      check("scrub_a1", 32'(sadd), 32'd1);
      tick(); sval = 32'h1;
      smp(); check("scrub_chk_we", 32'(we), 32'd0);
      check("scrub_suce", 32'(suce), 32'd0);
      tick(); sval = 32'h0;
      smp(); wr_chk("scrub_fix1", 5'd1, 32'h0);
      for (int a = 2; a <= 32; a++) begin
        wait_req(ok);
        check("scrub_to", 32'(ok), 32'd1);
        check("scrub_add", 32'(sadd),
              (a == 32) ? 32'd1 : 32'(a));
        if (!ok) break;
      end
    end
`else
    check("noscrub_req", 32'(sreq), 32'd0);
    check("noscrub_uce", 32'(suce), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
